// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline decode side.
// Holds opcode encodings, bundle widths/offsets, the decoded control
// struct and the opcode decode helper used by decode_exmem_unit.
package pipe_pkg;

  // Widths
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int OP_W       = 3;
  localparam int INSTR_W    = 32;
  localparam int ID_EX_W    = 40;
  localparam int EX_MEM_W   = 70;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;

  // Opcodes
  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_LDM = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_STD = 3'b011;
  localparam logic [OP_W-1:0] OP_LDD = 3'b100;

  // IF/ID instruction fields
  localparam int INSTR_OP_LSB   = 29;
  localparam int INSTR_RDST_LSB = 21;
  localparam int INSTR_RSRC_LSB = 18;
  localparam int INSTR_IMM_LSB  = 0;

  // ID/EX bundle offsets
  localparam int ID_EX_RDST_LSB  = 37;
  localparam int ID_EX_WB_BIT    = 36;
  localparam int ID_EX_MW_BIT    = 35;
  localparam int ID_EX_MR_BIT    = 34;
  localparam int ID_EX_ALU_BIT   = 33;
  localparam int ID_EX_ALUOP_BIT = 32;
  localparam int ID_EX_DATA1_LSB = 16;
  localparam int ID_EX_DATA2_LSB = 0;

  // EX/MEM bundle offsets
  localparam int EX_MEM_RDST_LSB = 67;
  localparam int EX_MEM_WB_BIT   = 66;
  localparam int EX_MEM_MW_BIT   = 65;
  localparam int EX_MEM_MR_BIT   = 64;
  localparam int EX_MEM_DATA_LSB = 32;
  localparam int EX_MEM_ADDR_LSB = 0;

  typedef struct packed {
    logic wb;
    logic mw;
    logic mr;
    logic alu;
    logic alu_op;
    logic imm;
  } ctrl_t;

  // Opcode to control bits; unlisted opcodes behave as NOP.
  function automatic ctrl_t decode_op(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_LDM: begin c.wb = 1'b1; c.alu = 1'b1; c.alu_op = 1'b1; c.imm = 1'b1; end
      OP_ADD: begin c.wb = 1'b1; c.alu = 1'b1; end
      OP_STD: begin c.mw = 1'b1; end
      OP_LDD: begin c.mr = 1'b1; c.wb = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// 8 x 16-bit register file, one write port and two combinational read ports.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all regs)
//   wr_en/wr_addr/wr_data  write port, captured on rising clk
//   rd_addr1/rd_data1   read port 1
//   rd_addr2/rd_data2   read port 2
// A read of the register being written this cycle returns wr_data directly,
// so the consumer sees the new value without waiting for the edge. The bypass
// is gated by rst_n so reads return the cleared contents during reset.
import pipe_pkg::*;

module reg_file_8x16 (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0]     rd_data1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]     rd_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              hit1;
  logic              hit2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign hit1 = rst_n && wr_en && (wr_addr == rd_addr1);
  assign hit2 = rst_n && wr_en && (wr_addr == rd_addr2);

  assign rd_data1 = hit1 ? wr_data : regs[rd_addr1];
  assign rd_data2 = hit2 ? wr_data : regs[rd_addr2];

endmodule

// File: rtl/decode_exmem_unit.sv
// Decode-side control block: opcode control unit, register file with
// immediate selection (combinational ID/EX bundle) and the EX/MEM register.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   instr        IF/ID word: [31:29] op, [23:21] Rdst, [20:18] Rsrc, [15:0] imm
//   wb_en/wb_addr/wb_data  MEM/WB write-back into the register file
//   id_ex        {Rdst, WB, MW, MR, ALU, ALUOp, Data1, Data2}, combinational
//   ex_mem_d     next EX/MEM bundle
//   ex_mem_q     registered EX/MEM bundle (no enable, no flush)
import pipe_pkg::*;

module decode_exmem_unit (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [ID_EX_W-1:0]    id_ex,
  input  logic [EX_MEM_W-1:0]   ex_mem_d,
  output logic [EX_MEM_W-1:0]   ex_mem_q
);

  logic [OP_W-1:0]       opcode;
  logic [REG_ADDR_W-1:0] rdst;
  logic [REG_ADDR_W-1:0] rsrc;
  logic [DATA_W-1:0]     imm;
  logic [DATA_W-1:0]     rd_data1;
  logic [DATA_W-1:0]     rd_data2;
  logic [DATA_W-1:0]     data2;
  ctrl_t                 ctrl;
  logic                  unused_instr_bits;

  assign opcode = instr[INSTR_OP_LSB   +: OP_W];
  assign rdst   = instr[INSTR_RDST_LSB +: REG_ADDR_W];
  assign rsrc   = instr[INSTR_RSRC_LSB +: REG_ADDR_W];
  assign imm    = instr[INSTR_IMM_LSB  +: DATA_W];

  // Bits 28:24 and 17:16 carry no meaning for this block.
  assign unused_instr_bits = ^{instr[28:24], instr[17:16]};

  assign ctrl = decode_op(opcode);

  reg_file_8x16 u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd_addr1 (rsrc),
    .rd_data1 (rd_data1),
    .rd_addr2 (rdst),
    .rd_data2 (rd_data2)
  );

  // Data2 carries the immediate for LDM, otherwise the Rdst register
  // (the store data for STD).
  assign data2 = ctrl.imm ? imm : rd_data2;

  assign id_ex = {rdst, ctrl.wb, ctrl.mw, ctrl.mr, ctrl.alu, ctrl.alu_op,
                  rd_data1, data2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

endmodule

// File: tb/tb_decode_exmem_unit.sv
// Directed bench for decode_exmem_unit. Inputs change on the falling edge,
// outputs are sampled 1 ns later, away from the rising edge.
module tb_decode_exmem_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [39:0] id_ex;
  logic [69:0] ex_mem_d;
  logic [69:0] ex_mem_q;

  int checks = 0;
  int errors = 0;

  decode_exmem_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .id_ex    (id_ex),
    .ex_mem_d (ex_mem_d),
    .ex_mem_q (ex_mem_q)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [2:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [15:0] im);
    return {op, 5'b0, rd, rs, 2'b0, im};
  endfunction

  // Driver tasks
  task automatic drive_wb(input logic en, input logic [2:0] a, input logic [15:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    drive_wb(1'b1, a, d);
    @(negedge clk);
    drive_wb(1'b0, 3'd0, 16'd0);
  endtask

  task automatic test_reset();
    // Load a register and ex_mem_q so reset has something to clear.
    write_reg(3'd3, 16'h0055);
    @(negedge clk);
    ex_mem_d = 70'h15_12345678_9ABCDEF0;
    instr = mk_instr(3'b010, 3'd3, 3'd3, 16'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;  // mid-cycle, no edge
    #1;
    checks++;
    if (ex_mem_q !== 70'd0) begin
      errors++; $display("FAIL reset_ex_mem: got %h expected 0", ex_mem_q);
    end
    checks++;
    if (id_ex !== {3'd3, 5'b10010, 16'h0000, 16'h0000}) begin
      errors++; $display("FAIL reset_reads: got %h expected %h", id_ex,
                         {3'd3, 5'b10010, 16'h0000, 16'h0000});
    end
    @(negedge clk);
    ex_mem_d = '0;
    rst_n = 1'b1;
    instr = mk_instr(3'b001, 3'd0, 3'd0, 16'd15);
    #1;
    checks++;
    if (id_ex !== {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'd15}) begin
      errors++; $display("FAIL reset_ldm: got %h expected %h", id_ex,
                         {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'd15});
    end
  endtask

  task automatic test_wb_bypass();
    @(negedge clk);
    drive_wb(1'b1, 3'd7, 16'd13);
    instr = mk_instr(3'b010, 3'd7, 3'd7, 16'hFFFF);
    #1;
    checks++;
    if (id_ex[31:0] !== {16'd13, 16'd13}) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected %h", id_ex[31:0], {16'd13, 16'd13});
    end
    @(negedge clk);
    drive_wb(1'b0, 3'd0, 16'd0);
    #1;
    checks++;
    if (id_ex[31:0] !== {16'd13, 16'd13}) begin
      errors++; $display("FAIL bypass_after_edge: got %h expected %h", id_ex[31:0], {16'd13, 16'd13});
    end
    // R0 = 15 via bypass on read port 1 only.
    @(negedge clk);
    drive_wb(1'b1, 3'd0, 16'd15);
    instr = mk_instr(3'b010, 3'd7, 3'd0, 16'd0);
    #1;
    checks++;
    if (id_ex[31:0] !== {16'd15, 16'd13}) begin
      errors++; $display("FAIL bypass_port1_r0: got %h expected %h", id_ex[31:0], {16'd15, 16'd13});
    end
    @(negedge clk);
    drive_wb(1'b0, 3'd0, 16'd0);
  endtask

  task automatic test_opcode_sweep();
    logic [4:0]  exp_ctrl [8];
    logic [15:0] exp_d2;
    // {WB, MW, MR, ALU, ALUOp}
    exp_ctrl[0] = 5'b00000; exp_ctrl[1] = 5'b10011;
    exp_ctrl[2] = 5'b10010; exp_ctrl[3] = 5'b01000;
    exp_ctrl[4] = 5'b10100; exp_ctrl[5] = 5'b00000;
    exp_ctrl[6] = 5'b00000; exp_ctrl[7] = 5'b00000;
    write_reg(3'd5, 16'h0A5A);
    for (int op = 0; op < 8; op++) begin
      @(negedge clk);
      instr = mk_instr(op[2:0], 3'd5, 3'd7, 16'h1234);
      instr[28:24] = 5'h1F;  // ignored bits
      instr[17:16] = 2'b11;
      exp_d2 = (op == 1) ? 16'h1234 : 16'h0A5A;
      #1;
      checks++;
      if (id_ex !== {3'd5, exp_ctrl[op], 16'd13, exp_d2}) begin
        errors++; $display("FAIL opcode_%0d: got %h expected %h", op, id_ex,
                           {3'd5, exp_ctrl[op], 16'd13, exp_d2});
      end
    end
  endtask

  task automatic test_std_ldd();
    @(negedge clk);
    instr = mk_instr(3'b011, 3'd7, 3'd0, 16'h0000);
    #1;
    checks++;
    if (id_ex !== {3'd7, 5'b01000, 16'd15, 16'd13}) begin
      errors++; $display("FAIL std: got %h expected %h", id_ex, {3'd7, 5'b01000, 16'd15, 16'd13});
    end
    @(negedge clk);
    instr = mk_instr(3'b100, 3'd5, 3'd7, 16'h0000);
    #1;
    checks++;
    if (id_ex !== {3'd5, 5'b10100, 16'd13, 16'h0A5A}) begin
      errors++; $display("FAIL ldd: got %h expected %h", id_ex, {3'd5, 5'b10100, 16'd13, 16'h0A5A});
    end
  endtask

  task automatic test_ex_mem();
    logic [69:0] exp_q[$];
    exp_q.push_back(70'h2A_DEADBEEF_0000000F);
    exp_q.push_back(70'h15_CAFEF00D_00001234);
    @(negedge clk);
    ex_mem_d = exp_q[0];
    #1;
    checks++;
    if (ex_mem_q !== 70'd0) begin
      errors++; $display("FAIL ex_mem_before_edge: got %h expected 0", ex_mem_q);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ex_mem_q !== exp_q[0]) begin
      errors++; $display("FAIL ex_mem_one_cycle: got %h expected %h", ex_mem_q, exp_q[0]);
    end
    ex_mem_d = exp_q[1];  // change between edges
    #1;
    checks++;
    if (ex_mem_q !== exp_q[0]) begin
      errors++; $display("FAIL ex_mem_hold: got %h expected %h", ex_mem_q, exp_q[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_q !== exp_q[1]) begin
      errors++; $display("FAIL ex_mem_second: got %h expected %h", ex_mem_q, exp_q[1]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ex_mem_q !== 70'd0) begin
      errors++; $display("FAIL ex_mem_async_clear: got %h expected 0", ex_mem_q);
    end
    @(negedge clk);
    ex_mem_d = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_write_in_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_wb(1'b1, 3'd2, 16'h7777);
    instr = mk_instr(3'b010, 3'd2, 3'd2, 16'h0000);
    #1;
    checks++;
    if (id_ex !== {3'd2, 5'b10010, 16'h0000, 16'h0000}) begin
      errors++; $display("FAIL reset_no_bypass: got %h expected %h", id_ex,
                         {3'd2, 5'b10010, 16'h0000, 16'h0000});
    end
    @(negedge clk);  // an edge passed with wb_en=1 under reset
    drive_wb(1'b0, 3'd0, 16'd0);
    #1;
    checks++;
    if (id_ex[31:0] !== 32'd0) begin
      errors++; $display("FAIL reset_no_write: got %h expected 0", id_ex[31:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_wb(1'b1, 3'd2, 16'h7777);
    @(negedge clk);
    drive_wb(1'b0, 3'd0, 16'd0);
    #1;
    checks++;
    if (id_ex[31:0] !== {16'h7777, 16'h7777}) begin
      errors++; $display("FAIL write_after_release: got %h expected %h", id_ex[31:0],
                         {16'h7777, 16'h7777});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr = '0;
    ex_mem_d = '0;
    drive_wb(1'b0, 3'd0, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_wb_bypass();
    test_opcode_sweep();
    test_std_ldd();
    test_ex_mem();
    test_write_in_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
